// File: rtl/multi_dataflow_roberts_mdc_package.sv
// Shared TCDM widths and counter type for the roberts_mdc streamer memory model.
package multi_dataflow_roberts_mdc_package;

  localparam int unsigned TCDM_DW  = 32;
  localparam int unsigned TCDM_BEW = 4;

  typedef logic [31:0] tcdm_resp_cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic tcdm_resp_cnt_t sat_inc(input tcdm_resp_cnt_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/roberts_mdc_tcdm_rr_arbiter.sv
// Round-robin single-winner arbiter; the pointer names the highest-priority port.
module roberts_mdc_tcdm_rr_arbiter #(
  parameter  int unsigned NP = 3,
  localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic [NP-1:0] eligible_i,
  output logic [NP-1:0] gnt_o,
  output logic [IW-1:0] winner_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o    = '0;
    winner_o = '0;
    found    = 1'b0;
    cand     = '0;
    // Walk cyclically from the pointer; the first eligible port wins.
    for (int i = 0; i < int'(NP); i++) begin
      cand = IW'((int'(ptr_q) + i) % int'(NP));
      if (!found && eligible_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        winner_o    = cand;
      end
    end
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (found) begin
      ptr_d = (winner_o == IW'(NP - 1)) ? '0 : winner_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/roberts_mdc_tcdm_responder.sv
// Multi-port TCDM slave: one shared word memory, round-robin grant, 1-cycle response.
module roberts_mdc_tcdm_responder
  import multi_dataflow_roberts_mdc_package::*;
#(
  parameter int unsigned NP        = 3,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned AW        = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [NP-1:0]        stall_i,
  input  logic [NP-1:0]        tcdm_req_i,
  output logic [NP-1:0]        tcdm_gnt_o,
  input  logic [NP*AW-1:0]     tcdm_add_i,
  input  logic [NP-1:0]        tcdm_wen_i,
  input  logic [NP*4-1:0]      tcdm_be_i,
  input  logic [NP*32-1:0]     tcdm_data_i,
  output logic [NP*32-1:0]     tcdm_r_data_o,
  output logic [NP-1:0]        tcdm_r_valid_o,
  output logic [31:0]          nb_rd_o,
  output logic [31:0]          nb_wr_o
);

  localparam int unsigned IDXW = $clog2(MEM_WORDS);
  localparam int unsigned IW   = (NP > 1) ? $clog2(NP) : 1;

  logic [NP-1:0]       eligible;
  logic [NP-1:0]       gnt;
  logic [IW-1:0]       winner;
  logic                any_gnt;
  logic [AW-1:0]       sel_add;
  logic [IDXW-1:0]     sel_idx;
  logic                sel_rd;
  logic [TCDM_BEW-1:0] sel_be;
  logic [TCDM_DW-1:0]  sel_wdata;
  logic                rd_en, wr_en;
  logic                unused_add;

  logic [TCDM_DW-1:0]    mem_q [MEM_WORDS];
  logic [NP*TCDM_DW-1:0] r_data_q, r_data_d;
  logic [NP-1:0]         r_valid_q, r_valid_d;
  tcdm_resp_cnt_t        nb_rd_q, nb_rd_d;
  tcdm_resp_cnt_t        nb_wr_q, nb_wr_d;

  // Gating eligibility with clear_i keeps grants out of the clear cycle.
  assign eligible = tcdm_req_i & ~stall_i & {NP{~clear_i}};

  roberts_mdc_tcdm_rr_arbiter #(.NP(NP)) i_arbiter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .eligible_i (eligible),
    .gnt_o      (gnt),
    .winner_o   (winner)
  );

  assign tcdm_gnt_o = gnt;
  assign any_gnt    = |gnt;
  assign sel_add    = tcdm_add_i[int'(winner)*AW +: AW];
  assign sel_idx    = sel_add[IDXW+1:2];
  assign sel_rd     = tcdm_wen_i[winner];
  assign sel_be     = tcdm_be_i[int'(winner)*TCDM_BEW +: TCDM_BEW];
  assign sel_wdata  = tcdm_data_i[int'(winner)*TCDM_DW +: TCDM_DW];
  assign rd_en      = any_gnt & sel_rd;
  assign wr_en      = any_gnt & ~sel_rd;
  assign unused_add = ^{sel_add[AW-1:IDXW+2], sel_add[1:0]};

  always_comb begin
    r_valid_d = clear_i ? '0 : gnt;
    r_data_d  = r_data_q;
    if (rd_en) begin
      r_data_d[int'(winner)*TCDM_DW +: TCDM_DW] = mem_q[sel_idx];
    end
    nb_rd_d = nb_rd_q;
    nb_wr_d = nb_wr_q;
    if (clear_i) begin
      nb_rd_d = '0;
      nb_wr_d = '0;
    end else begin
      if (rd_en) nb_rd_d = sat_inc(nb_rd_q);
      if (wr_en) nb_wr_d = sat_inc(nb_wr_q);
    end
  end

  // Memory has no reset so contents survive rst_ni and clear_i.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < int'(TCDM_BEW); k++) begin
        if (sel_be[k]) mem_q[sel_idx][8*k +: 8] <= sel_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data_q  <= '0;
      r_valid_q <= '0;
      nb_rd_q   <= '0;
      nb_wr_q   <= '0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      nb_rd_q   <= nb_rd_d;
      nb_wr_q   <= nb_wr_d;
    end
  end

  assign tcdm_r_data_o  = r_data_q;
  assign tcdm_r_valid_o = r_valid_q;
  assign nb_rd_o        = nb_rd_q;
  assign nb_wr_o        = nb_wr_q;

endmodule

// File: tb/tb_roberts_mdc_tcdm_responder.sv
// Vector-table bench with a response scoreboard for roberts_mdc_tcdm_responder.
module tb_roberts_mdc_tcdm_responder;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int MEM_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic [NP-1:0]     stall_i;
  logic [NP-1:0]     tcdm_req_i;
  logic [NP-1:0]     tcdm_gnt_o;
  logic [NP*AW-1:0]  tcdm_add_i;
  logic [NP-1:0]     tcdm_wen_i;
  logic [NP*4-1:0]   tcdm_be_i;
  logic [NP*32-1:0]  tcdm_data_i;
  logic [NP*32-1:0]  tcdm_r_data_o;
  logic [NP-1:0]     tcdm_r_valid_o;
  logic [31:0]       nb_rd_o;
  logic [31:0]       nb_wr_o;

  roberts_mdc_tcdm_responder #(.NP(NP), .MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .stall_i        (stall_i),
    .tcdm_req_i     (tcdm_req_i),
    .tcdm_gnt_o     (tcdm_gnt_o),
    .tcdm_add_i     (tcdm_add_i),
    .tcdm_wen_i     (tcdm_wen_i),
    .tcdm_be_i      (tcdm_be_i),
    .tcdm_data_i    (tcdm_data_i),
    .tcdm_r_data_o  (tcdm_r_data_o),
    .tcdm_r_valid_o (tcdm_r_valid_o),
    .nb_rd_o        (nb_rd_o),
    .nb_wr_o        (nb_wr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             clr;
    logic [2:0]       req;
    logic [2:0]       stall;
    logic [2:0]       wen;
    logic [2:0][31:0] add;
    logic [2:0][31:0] wdata;
    logic [2:0][3:0]  be;
    logic [2:0]       exp_gnt;
    logic [31:0]      exp_rdata;
  } vec_t;

  typedef struct {
    int          port;
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] m_rd     = 0;
  logic [31:0] m_wr     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic clr, input logic [2:0] req, input logic [2:0] stall,
                              input logic [2:0] wen, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [11:0] be, input logic [2:0] eg,
                              input logic [31:0] er);
    vec_t v;
    v.clr = clr; v.req = req; v.stall = stall; v.wen = wen;
    v.add[0] = a0; v.add[1] = a1; v.add[2] = a2;
    v.wdata[0] = d0; v.wdata[1] = d1; v.wdata[2] = d2;
    v.be = be; v.exp_gnt = eg; v.exp_rdata = er;
    return v;
  endfunction

  function automatic int oh2idx(input logic [2:0] oh);
    int r = 0;
    for (int i = 0; i < NP; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    clear_i    = v.clr;
    stall_i    = v.stall;
    tcdm_req_i = v.req;
    tcdm_wen_i = v.wen;
    for (int p = 0; p < NP; p++) begin
      tcdm_add_i[p*AW +: AW]  = v.add[p];
      tcdm_data_i[p*32 +: 32] = v.wdata[p];
      tcdm_be_i[p*4 +: 4]     = v.be[p];
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    @(posedge clk);
    #1 drive(v);
    @(negedge clk);
    #1;
    $display("vec %0d cyc %0d clr=%b req=%b stall=%b gnt=%b", id, cyc, v.clr, v.req, v.stall, tcdm_gnt_o);
    n_checks++;
    if (tcdm_gnt_o !== v.exp_gnt) begin
      n_fail++;
      $display("FAIL gnt vec %0d: got %b want %b", id, tcdm_gnt_o, v.exp_gnt);
    end
    if (v.clr) begin
      m_rd = 0;
      m_wr = 0;
    end else if (v.exp_gnt != 0) begin
      exp_t e;
      e.port = oh2idx(v.exp_gnt);
      e.rd   = v.wen[e.port];
      e.data = v.exp_rdata;
      e.cyc  = cyc;
      sb.push_back(e);
      if (e.rd) m_rd = m_rd + 1;
      else      m_wr = m_wr + 1;
    end
  endtask

  // Response and counter monitor; also holds masters to the stable-until-grant rule.
  initial begin
    logic [2:0]       prev_req = 0;
    logic [2:0]       prev_gnt = 0;
    logic [2:0]       prev_wen = 0;
    logic [NP*AW-1:0] prev_add = 0;
    logic [2:0]       exp_v;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        sb.delete();
        prev_req = 0;
      end else begin
        exp_v = 3'b000;
        if (sb.size() > 0 && sb[0].cyc == cyc - 1) exp_v = 3'(1 << sb[0].port);
        n_checks++;
        if (tcdm_r_valid_o !== exp_v) begin
          n_fail++;
          $display("FAIL r_valid cyc %0d: got %b want %b", cyc, tcdm_r_valid_o, exp_v);
        end
        if (exp_v != 0) begin
          e = sb.pop_front();
          if (e.rd) begin
            n_checks++;
            if (tcdm_r_data_o[e.port*32 +: 32] !== e.data) begin
              n_fail++;
              $display("FAIL r_data port %0d cyc %0d: got %h want %h", e.port, cyc,
                       tcdm_r_data_o[e.port*32 +: 32], e.data);
            end
          end
        end
        n_checks += 2;
        if (nb_rd_o !== m_rd) begin
          n_fail++;
          $display("FAIL nb_rd cyc %0d: got %0d want %0d", cyc, nb_rd_o, m_rd);
        end
        if (nb_wr_o !== m_wr) begin
          n_fail++;
          $display("FAIL nb_wr cyc %0d: got %0d want %0d", cyc, nb_wr_o, m_wr);
        end
        for (int p = 0; p < NP; p++) begin
          if (prev_req[p] && !prev_gnt[p] &&
              (!tcdm_req_i[p] || tcdm_wen_i[p] !== prev_wen[p] ||
               tcdm_add_i[p*AW +: AW] !== prev_add[p*AW +: AW])) begin
            n_fail++;
            $display("FAIL master_hold port %0d cyc %0d: got req=%b want req held", p, cyc, tcdm_req_i[p]);
          end
        end
        prev_req = tcdm_req_i;
        prev_gnt = tcdm_gnt_o;
        prev_wen = tcdm_wen_i;
        prev_add = tcdm_add_i;
      end
    end
  end

  initial begin
    vec_t idle;
    idle = mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 12'h000, 3'b000, 0);

    vecs.push_back(mk(0, 3'b100, 3'b000, 3'b000, 0, 0, 32'h10, 0, 0, 32'hDEADBEEF, 12'hF00, 3'b100, 0));
    vecs.push_back(mk(0, 3'b001, 3'b000, 3'b001, 32'h10, 0, 0, 0, 0, 0, 12'h000, 3'b001, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'b010, 3'b000, 3'b000, 0, 32'h10, 0, 0, 32'h11223344, 0, 12'h050, 3'b010, 0));
    vecs.push_back(mk(0, 3'b010, 3'b000, 3'b010, 0, 32'h10, 0, 0, 0, 0, 12'h000, 3'b010, 32'hDE22BE44));
    vecs.push_back(mk(0, 3'b100, 3'b000, 3'b000, 0, 0, 32'h30, 0, 0, 32'h30303030, 12'hF00, 3'b100, 0));
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(mk(0, 3'b111, 3'b000, 3'b001, 32'h10, 32'h20, 32'h30, 0, 32'h20202020, 32'h30303030,
                        12'hFF0, 3'(1 << (i % 3)), (i % 3 == 0) ? 32'hDE22BE44 : 32'h0));
    end
    vecs.push_back(mk(0, 3'b011, 3'b000, 3'b001, 32'h10, 32'h20, 32'h30, 0, 32'h20202020, 0, 12'h0F0, 3'b001, 32'hDE22BE44));
    vecs.push_back(mk(0, 3'b010, 3'b000, 3'b001, 32'h10, 32'h20, 32'h30, 0, 32'h20202020, 0, 12'h0F0, 3'b010, 0));
    vecs.push_back(mk(1, 3'b011, 3'b000, 3'b011, 32'h10, 32'h20, 0, 0, 0, 0, 12'h000, 3'b000, 0));
    vecs.push_back(mk(0, 3'b011, 3'b001, 3'b011, 32'h10, 32'h20, 0, 0, 0, 0, 12'h000, 3'b010, 32'h20202020));
    vecs.push_back(mk(0, 3'b001, 3'b000, 3'b011, 32'h10, 32'h20, 0, 0, 0, 0, 12'h000, 3'b001, 32'hDE22BE44));
    vecs.push_back(mk(0, 3'b001, 3'b000, 3'b000, 32'h1000, 0, 0, 32'hA5A5A5A5, 0, 0, 12'h00F, 3'b001, 0));
    vecs.push_back(mk(0, 3'b010, 3'b000, 3'b010, 0, 32'h0, 0, 0, 0, 0, 12'h000, 3'b010, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 3'b110, 3'b111, 3'b110, 0, 32'h10, 32'h30, 0, 0, 0, 12'h000, 3'b000, 0));
    vecs.push_back(mk(0, 3'b110, 3'b000, 3'b110, 0, 32'h10, 32'h30, 0, 0, 0, 12'h000, 3'b100, 32'h30303030));
    vecs.push_back(mk(0, 3'b010, 3'b000, 3'b110, 0, 32'h10, 32'h30, 0, 0, 0, 12'h000, 3'b010, 32'hDE22BE44));
    vecs.push_back(idle);

    rst_ni = 1'b0;
    drive(idle);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_ni = 1'b1;
    chk("reset_r_valid", 32'(tcdm_r_valid_o), 0);
    chk("reset_r_data0", tcdm_r_data_o[31:0], 0);
    chk("reset_nb_rd", nb_rd_o, 0);
    chk("reset_nb_wr", nb_wr_o, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset while a read response is on the bus.
    apply(mk(0, 3'b001, 3'b000, 3'b001, 32'h20, 0, 0, 0, 0, 0, 12'h000, 3'b001, 32'h20202020), 100);
    @(posedge clk);
    #1 drive(idle);
    chk("rvalid_before_rst", 32'(tcdm_r_valid_o), 32'h1);
    #1 rst_ni = 1'b0;
    m_rd = 0;
    m_wr = 0;
    #1;
    chk("rvalid_async_rst", 32'(tcdm_r_valid_o), 0);
    chk("rdata_async_rst", tcdm_r_data_o[31:0], 0);
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b1;
    apply(mk(0, 3'b100, 3'b000, 3'b100, 0, 0, 32'h0, 0, 0, 0, 12'h000, 3'b100, 32'hA5A5A5A5), 101);
    apply(idle, 102);
    repeat (2) @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/roberts_mdc_tcdm_responder.md
Name: roberts_mdc_tcdm_responder

Overview:
- Multi-port TCDM slave: the responder end of the TCDM master ports driven by the roberts_mdc streamer (2 load ports, 1 store port).
- Backs all ports with one shared single-access word memory behind a round-robin arbiter. Grant and response timing follow the hwpe TCDM protocol.
- Used as the memory model in accelerator-level benches, and as a standalone scratch TCDM in FPGA test wrappers.
- Exposes grant-stall injection and access counters so the streamer can be exercised under back-pressure.

Parameters:
- NP, 3, number of TCDM slave ports.
- MEM_WORDS, 1024, memory depth in 32-bit words; power of 2, >= 2.
- AW, 32, TCDM byte-address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous soft clear.
- stall_i  in  NP  per-port grant mask; 1 = port may not be granted this cycle.
- tcdm_req_i  in  NP  request per port.
- tcdm_gnt_o  out  NP  grant per port (combinational).
- tcdm_add_i  in  NP*AW  byte address per port.
- tcdm_wen_i  in  NP  1 = read, 0 = write.
- tcdm_be_i  in  NP*4  byte enables per port.
- tcdm_data_i  in  NP*32  write data per port.
- tcdm_r_data_o  out  NP*32  read data per port (registered).
- tcdm_r_valid_o  out  NP  response valid per port (registered).
- nb_rd_o  out  32  granted-read counter, saturating.
- nb_wr_o  out  32  granted-write counter, saturating.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - tcdm_r_valid_o=0, tcdm_r_data_o=0, nb_rd_o=0, nb_wr_o=0.
  - Arbiter pointer=0.
  - Memory contents are not reset.
- Eligibility: port p is eligible iff tcdm_req_i[p] & ~stall_i[p].
- Grant:
  - At most one grant per cycle, issued in the same cycle as the request.
  - Winner is the first eligible port at or after the pointer, cyclically.
  - After a grant, pointer <= winner+1 mod NP. With no grant, the pointer holds.
- Master rule: req, add, wen, be and data are held stable until gnt. The responder does not check this; the bench asserts it.
- Word index = tcdm_add_i[p][2+$clog2(MEM_WORDS)-1:2]. Upper bits are ignored, so addresses alias modulo MEM_WORDS*4. Bits [1:0] are ignored.
- Granted write (wen=0): at the clock edge ending the grant cycle, mem[idx] byte k <= data byte k wherever be[k]=1.
- Granted read (wen=1): tcdm_r_data_o[p] <= mem[idx] at the same edge.
- Response:
  - tcdm_r_valid_o[p]=1 exactly one cycle after gnt[p] (latency 1), for both reads and writes.
  - Otherwise tcdm_r_valid_o[p]=0.
  - tcdm_r_data_o[p] holds its value until the next granted read on p; writes do not update it.
- Back-to-back accesses: a read granted in the cycle after a write to the same word returns the new data. No bypass is needed because accesses are serialized.
- Ordering: a port with consecutive grants receives responses in grant order, one per cycle.
- Counters: increment nb_rd_o on each granted read and nb_wr_o on each granted write; both saturate at 32'hFFFF_FFFF.
- clear_i=1:
  - Next cycle: pointer=0, r_valid=0, counters=0.
  - No grants are issued while clear_i=1.
  - r_data and memory are untouched.
- Reset asserted mid-burst: pending responses are dropped (r_valid=0 immediately). Memory keeps any writes already committed.
- stall_i on all ports: no grants, pointer holds, counters hold.

Decomposition:
- multi_dataflow_roberts_mdc_package adds:
  - TCDM_DW=32 and TCDM_BEW=4;
  - typedef tcdm_resp_cnt_t (32-bit).
- Sub-module roberts_mdc_tcdm_rr_arbiter (NP parameter):
  - inputs: eligible vector, clear;
  - outputs: one-hot grant and winner index;
  - owns the pointer register.
- The top level holds the memory array, the response registers and the counters.

Test Plan:
- Reset, then write port2 addr 0x10 data 0xDEADBEEF be=4'hF, then read port0 addr 0x10 -> gnt same cycle; r_valid[0] one cycle later with r_data=0xDEADBEEF; nb_wr_o=1, nb_rd_o=1.
- Partial write: be=4'b0101 data 0x11223344 over 0xDEADBEEF at addr 0x10, then read -> 0xDE22BE44.
- All 3 ports request continuously for 6 cycles, no stall -> grants in order 0,1,2,0,1,2; each r_valid exactly one cycle after its gnt.
- stall_i=3'b001 while ports 0 and 1 request, pointer=0 -> port1 granted; after stall drops, port0 granted next; port0 never starves.
- Alias check with MEM_WORDS=1024: write 0xA5A5A5A5 to addr 0x1000, then read addr 0x0 -> 0xA5A5A5A5.
- Mid-burst events:
  - Assert rst_ni=0 while r_valid=1 -> r_valid drops in the same cycle; after release, read of a previously written word returns its data.
  - clear_i pulse -> counters=0 and no grant during the clear cycle.
